// File: rtl/unroller.sv
`default_nettype none
// ============================================================================
//  Module   : unroller
//  Purpose  : Gathers ROLL_NUM-element input beats into NUM-element vectors
//             behind a one-deep output register (inverse of roller).
//  Revision : 1.0 - initial release
// ============================================================================
module unroller #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM        = 4,
    parameter int ROLL_NUM   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in [ROLL_NUM],
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out [NUM],
    output logic                  data_out_valid,
    input  logic                  data_out_ready
);

    localparam int BEATS     = NUM / ROLL_NUM;
    localparam int CNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LAST_BASE = (BEATS - 1) * ROLL_NUM;
    localparam logic [CNT_WIDTH-1:0] C_LAST_CNT = CNT_WIDTH'(BEATS - 1);

    generate
        if ((ROLL_NUM < 1) || (NUM < ROLL_NUM) || ((NUM % ROLL_NUM) != 0)) begin : g_bad_ratio
            $error("unroller: NUM must be a positive integer multiple of ROLL_NUM");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] asm_q [NUM];
    logic [DATA_WIDTH-1:0] asm_d [NUM];
    logic [DATA_WIDTH-1:0] out_q [NUM];
    logic [DATA_WIDTH-1:0] out_d [NUM];
    logic                  out_valid_q;
    logic                  out_valid_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_d;

    logic w_last;
    logic w_accept;
    logic w_drain;

    assign w_last        = (cnt_q == C_LAST_CNT);
    assign data_in_ready = !rst && (!w_last || !out_valid_q || data_out_ready);
    assign w_accept      = data_in_valid && data_in_ready;
    assign w_drain       = out_valid_q && data_out_ready;

    always_comb begin
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        if (w_drain) begin
            out_valid_d = 1'b0;
        end

        if (w_accept) begin
            if (w_last) begin
                // Final slice bypasses asm_q so the vector is ready one cycle later.
                cnt_d = '0;
                for (int i = 0; i < LAST_BASE; i++) begin
                    out_d[i] = asm_q[i];
                end
                for (int j = 0; j < ROLL_NUM; j++) begin
                    out_d[LAST_BASE + j] = data_in[j];
                end
                out_valid_d = 1'b1;
            end else begin
                for (int j = 0; j < ROLL_NUM; j++) begin
                    if ((int'(cnt_q) * ROLL_NUM + j) < NUM) begin
                        asm_d[int'(cnt_q) * ROLL_NUM + j] = data_in[j];
                    end
                end
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NUM; i++) begin
                asm_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            asm_q       <= asm_d;
            out_q       <= out_d;
        end
    end

    assign data_out       = out_q;
    assign data_out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_unroller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_unroller
//  Purpose  : Directed, table-driven self-checking bench for unroller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_unroller;

    logic       clk;
    logic       rst;

    logic [7:0] din [2];
    logic       din_valid;
    logic       din_ready;
    logic [7:0] dout [4];
    logic       dout_valid;
    logic       dout_ready;

    logic [7:0] g_din [2];
    logic       g_din_valid;
    logic       g_din_ready;
    logic [7:0] g_dout [2];
    logic       g_dout_valid;
    logic       g_dout_ready;

    int total;
    int bad;

    unroller #(.DATA_WIDTH(8), .NUM(4), .ROLL_NUM(2)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (din),
        .data_in_valid  (din_valid),
        .data_in_ready  (din_ready),
        .data_out       (dout),
        .data_out_valid (dout_valid),
        .data_out_ready (dout_ready)
    );

    unroller #(.DATA_WIDTH(8), .NUM(2), .ROLL_NUM(2)) u_deg (
        .clk            (clk),
        .rst            (rst),
        .data_in        (g_din),
        .data_in_valid  (g_din_valid),
        .data_in_ready  (g_din_ready),
        .data_out       (g_dout),
        .data_out_valid (g_dout_valid),
        .data_out_ready (g_dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic        ordy;
        logic        exp_rdy;
        logic        exp_ov;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [31:0] pack4();
        return {dout[3], dout[2], dout[1], dout[0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs are applied just after an edge; ready is checked before the next
    // edge and the registered outputs just after it.
    task automatic apply(input vec_t r, input string tag);
        din_valid  = r.valid;
        din[0]     = r.d0;
        din[1]     = r.d1;
        dout_ready = r.ordy;
        #1;
        check({tag, ".in_ready"}, 32'(din_ready), 32'(r.exp_rdy));
        tick();
        check({tag, ".out_valid"}, 32'(dout_valid), 32'(r.exp_ov));
        if (r.exp_ov) check({tag, ".data"}, pack4(), r.exp_data);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        din_valid = 1'b0; din[0] = '0; din[1] = '0; dout_ready = 1'b0;
        g_din_valid = 1'b0; g_din[0] = '0; g_din[1] = '0; g_dout_ready = 1'b0;

        // Basic gather followed by backpressure with same-cycle drain and refill
        vecs[0] = '{1'b1, 8'h01, 8'h02, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 8'h03, 8'h04, 1'b1, 1'b1, 1'b1, 32'h04030201};
        vecs[2] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 8'h10, 8'h11, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 8'h12, 8'h13, 1'b0, 1'b1, 1'b1, 32'h13121110};
        vecs[5] = '{1'b1, 8'h14, 8'h15, 1'b0, 1'b1, 1'b1, 32'h13121110};
        vecs[6] = '{1'b1, 8'h16, 8'h17, 1'b0, 1'b0, 1'b1, 32'h13121110};
        vecs[7] = '{1'b1, 8'h16, 8'h17, 1'b1, 1'b1, 1'b1, 32'h17161514};
        vecs[8] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0};

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst.in_ready", 32'(din_ready), 32'd0);
            check("rst.deg_in_ready", 32'(g_din_ready), 32'd0);
        end
        rst = 1'b0;
        #1;
        check("post_rst.out_valid", 32'(dout_valid), 32'd0);
        check("post_rst.in_ready", 32'(din_ready), 32'd1);
        check("post_rst.data", pack4(), 32'h0);
        tick();

        for (int i = 0; i < 9; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Streaming: 16 beats, vector completes on every odd beat
        for (int b = 0; b < 16; b++) begin
            vec_t r;
            r.valid    = 1'b1;
            r.d0       = 8'(2 * b);
            r.d1       = 8'(2 * b + 1);
            r.ordy     = 1'b1;
            r.exp_rdy  = 1'b1;
            r.exp_ov   = 1'(b % 2);
            r.exp_data = {8'(2 * b + 1), 8'(2 * b), 8'(2 * b - 1), 8'(2 * b - 2)};
            apply(r, $sformatf("stream%0d", b));
        end
        din_valid = 1'b0;
        tick();
        check("stream.drained", 32'(dout_valid), 32'd0);

        // Reset mid-vector discards the partial assembly
        din_valid = 1'b1; din[0] = 8'hAA; din[1] = 8'hBB; dout_ready = 1'b1;
        tick();
        din_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst.out_valid", 32'(dout_valid), 32'd0);
        din_valid = 1'b1; din[0] = 8'h01; din[1] = 8'h02;
        tick();
        check("midrst.no_early", 32'(dout_valid), 32'd0);
        din[0] = 8'h03; din[1] = 8'h04;
        tick();
        din_valid = 1'b0;
        check("midrst.out_valid2", 32'(dout_valid), 32'd1);
        check("midrst.data", pack4(), 32'h04030201);
        tick();
        check("midrst.single", 32'(dout_valid), 32'd0);

        // Degenerate NUM == ROLL_NUM: register slice behaviour
        g_din_valid = 1'b1; g_din[0] = 8'h5A; g_din[1] = 8'hA5; g_dout_ready = 1'b0;
        #1;
        check("deg.rdy0", 32'(g_din_ready), 32'd1);
        tick();
        check("deg.valid", 32'(g_dout_valid), 32'd1);
        check("deg.data", {16'h0, g_dout[1], g_dout[0]}, 32'h0000A55A);
        g_din[0] = 8'h11; g_din[1] = 8'h22;
        #1;
        check("deg.blocked", 32'(g_din_ready), 32'd0);
        tick();
        check("deg.hold", {16'h0, g_dout[1], g_dout[0]}, 32'h0000A55A);
        g_dout_ready = 1'b1;
        #1;
        check("deg.rdy_drain", 32'(g_din_ready), 32'd1);
        tick();
        g_din_valid = 1'b0;
        check("deg.valid2", 32'(g_dout_valid), 32'd1);
        check("deg.data2", {16'h0, g_dout[1], g_dout[0]}, 32'h00002211);
        tick();
        check("deg.drained", 32'(g_dout_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/unroller.md
Name: unroller

Overview:
- Gathers a stream of narrow ROLL_NUM-element beats into full NUM-element parallel vectors. It is the inverse of roller.
- Sits after per-element compute stages such as activation LUTs. It restores the original block parallelism before the next layer or an output FIFO.
- Uses valid/ready handshakes on both sides and sustains one input beat per cycle.

Parameters:
- DATA_WIDTH, 8, bit width of each element.
- NUM, 4, elements per output vector.
- ROLL_NUM, 2, elements per input beat. NUM must be an integer multiple of ROLL_NUM; elaboration fails otherwise.
- BEATS (localparam), NUM/ROLL_NUM, input beats per output vector.
- CNT_WIDTH (localparam), max(1, $clog2(BEATS)), width of the beat counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- data_in  input  [DATA_WIDTH-1:0] x ROLL_NUM (unpacked)  incoming beat.
- data_in_valid  input  1  beat valid.
- data_in_ready  output  1  beat accepted when valid && ready.
- data_out  output  [DATA_WIDTH-1:0] x NUM (unpacked)  assembled vector.
- data_out_valid  output  1  vector valid.
- data_out_ready  input  1  downstream accepts when valid && ready.

Behaviour:
- Storage
  - Assembly register asm_q[NUM].
  - Output register out_q[NUM] with flag out_valid_q.
  - Beat counter cnt_q, range 0..BEATS-1.
- Ordering
  - The beat accepted while cnt_q==k writes asm_q[k*ROLL_NUM +: ROLL_NUM].
  - data_in[j] maps to element k*ROLL_NUM+j, so the first beat carries the lowest indices. This matches the roller emit order exactly.
- Accept rule: data_in_ready = !rst && ((cnt_q != BEATS-1) || !out_valid_q || data_out_ready).
  - Non-last beats are always accepted.
  - The last beat is accepted only if the output register is empty or drains in the same cycle.
- On acceptance of a non-last beat: write the slice, then cnt_q <= cnt_q+1.
- On acceptance of the last beat:
  - cnt_q <= 0.
  - out_q <= asm_q with the final slice replaced by data_in.
  - out_valid_q <= 1.
- Output drain: if data_out_valid && data_out_ready and no last beat completes this cycle, out_valid_q <= 0.
  - A simultaneous drain and last-beat completion keeps out_valid_q=1 and loads the new vector. There is no bubble.
- Outputs: data_out = out_q and data_out_valid = out_valid_q, both driven straight from registers.
- Latency: last beat accepted at cycle t gives data_out_valid=1 at t+1.
- Throughput: with data_out_ready held at 1, one vector per BEATS cycles and no input stall.
- Stability: while data_out_valid && !data_out_ready, data_out must not change.
- Backpressure: with the output held and assembly complete up to the last slot, data_in_ready=0. Earlier beats of the next vector still fill asm_q.
- BEATS==1: cnt_q stays 0 and every beat is a last beat. The block degenerates to a one-deep register slice with latency 1.
- Reset (synchronous, rst=1 at a rising edge):
  - cnt_q <= 0, out_valid_q <= 0, out_q <= 0, asm_q <= 0.
  - data_in_ready=0 while rst=1.
  - A partially assembled vector is discarded and never emitted.
  - A pending output vector is dropped.
- After reset deasserts: data_out_valid=0, data_in_ready=1, data_out all zeros.
- Unused asm_q slots are don't-care, but must be reset for X-clean simulation.

Decomposition:
- No shared-package entries. BEATS and CNT_WIDTH are module localparams derived from parameters.
- Single module, no sub-module. The output stage is a few lines and is kept inline so that the drain/complete interaction stays in one always_ff block.

Test Plan (DATA_WIDTH=8, NUM=4, ROLL_NUM=2 unless stated):
1. Reset: hold rst 3 cycles, then release -> data_out_valid=0, data_in_ready=1, data_out={0,0,0,0}; data_in_ready=0 while rst=1.
2. Basic gather: beats {[0]=0x01,[1]=0x02} then {0x03,0x04}, data_out_ready=1 -> one cycle after the second accept, data_out[0..3]=01,02,03,04 with valid high for exactly one cycle.
3. Backpressure: data_out_ready=0, offer beats 0x10..0x17 (4 beats) -> vector 10,11,12,13 holds stable; beat 3 accepted; beat 4 sees ready=0; raise data_out_ready -> beat 4 accepted in the drain cycle; next cycle data_out=14,15,16,17 with no bubble.
4. Streaming: continuous valid, data_out_ready=1, 16 beats -> 8 vectors, data_out_valid on every other cycle, data_in_ready never 0, order preserved.
5. Reset mid-vector: accept beat {0xAA,0xBB}, pulse rst, then send {0x01,0x02},{0x03,0x04} -> single vector 01,02,03,04; 0xAA/0xBB never appear.
6. Degenerate NUM=ROLL_NUM=2: beat {0x5A,0xA5} -> data_out={0x5A,0xA5} valid next cycle; under data_out_ready=0, data_in_ready=0 until drained.
